pdm_decimator: RTL and testbench

- Receive-side counterpart of the synth's 1-bit DAC output.
- Takes the 1-bit sigma-delta/PDM stream, applies a 3rd-order CIC decimator (integrators at bit rate, combs at sample rate) and emits 16-bit unsigned PCM samples with a one-cycle valid strobe.
- With defaults it turns the 20480000 Hz bitstream into 40000 Hz samples, matching the synth sample rate.
- Used in loopback self-test and in benches to recover the audio waveform from the modulator output.

---
 rtl/pdm_decimator.sv | 74 +++++++
 tb/tb_pdm_decimator.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_decimator.sv
// Third-order CIC decimator: 1-bit PDM stream in, 16-bit unsigned PCM out.
// Integrators run on every enabled bit; combs run once per R bits.
module pdm_decimator #(
  parameter int DECIM_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        settled
);

  localparam int W   = 3*DECIM_LOG2 + 1;
  localparam int MSB = 3*DECIM_LOG2;

  logic [W-1:0]            i1, i2, i3;
  logic [W-1:0]            d1, d2, d3;
  logic [W-1:0]            c1, c2;
  logic [16:0]             c3_top;
  logic [MSB-17:0]         c3_unused;
  logic [DECIM_LOG2-1:0]   phase;
  logic [1:0]              sample_cnt;
  logic                    dec_event;
  logic [15:0]             scaled;

  assign dec_event = en && (phase == {DECIM_LOG2{1'b1}});

  // Registers wrap modulo 2^W; the comb differences recover the exact sum.
  always_comb begin
    c1 = i3 - d1;
    c2 = c1 - d2;
    {c3_top, c3_unused} = c2 - d3;
    scaled = c3_top[16] ? 16'hFFFF : c3_top[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      d1         <= '0;
      d2         <= '0;
      d3         <= '0;
      phase      <= '0;
      sample_cnt <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      settled    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (en) begin
        i1    <= i1 + {{(W-1){1'b0}}, din};
        i2    <= i2 + i1;
        i3    <= i3 + i2;
        phase <= phase + 1'b1;
      end
      if (dec_event) begin
        d1         <= i3;
        d2         <= c1;
        d3         <= c2;
        dout       <= scaled;
        dout_valid <= 1'b1;
        if (sample_cnt != 2'd3)
          sample_cnt <= sample_cnt + 2'd1;
        // Two samples carry the filter start-up transient.
        if (sample_cnt == 2'd2)
          settled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// Bench for pdm_decimator: per-cycle comparison against a closed-form CIC model
// (weighted sums of the accepted bit history), plus fixed-value spot checks.
module tb_pdm_decimator;

  localparam int L   = 9;
  localparam int R   = 1 << L;
  localparam int MSB = 3*L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        din = 1'b0;
  logic [15:0] dout;
  logic        dout_valid;
  logic        settled;

  int vectors     = 0;
  int miscompares = 0;

  pdm_decimator #(.DECIM_LOG2(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  // Model: the third integrator before edge n holds sum_j x[j]*C(n-1-j,2);
  // the output is the third difference of that quantity sampled every R bits.
  bit          bits[$];
  longint      xs[$];
  bit          model_live = 1'b0;
  logic [15:0] exp_dout    = '0;
  logic        exp_valid   = 1'b0;
  logic        exp_settled = 1'b0;
  int          exp_count   = 0;

  function automatic longint integ3(int n);
    longint acc = 0;
    for (int j = 0; j <= n - 3; j++) begin
      if (bits[j]) begin
        longint a;
        a = longint'(n - 1 - j);
        acc += a * (a - 1) / 2;
      end
    end
    return acc;
  endfunction

  function automatic logic [15:0] scale(longint y);
    if (y >= (longint'(1) << MSB)) return 16'hFFFF;
    return 16'(y >> (MSB - 16));
  endfunction

  always @(posedge clk) begin : model
    longint xk, y;
    int     k;
    if (rst) begin
      bits.delete();
      xs.delete();
      exp_dout    <= '0;
      exp_valid   <= 1'b0;
      exp_settled <= 1'b0;
      exp_count   <= 0;
      model_live  <= 1'b1;
    end else begin
      exp_valid <= 1'b0;
      if (en) begin
        bits.push_back(din);
        if (bits.size() % R == 0) begin
          xk = integ3(bits.size() - 1);
          xs.push_back(xk);
          k = xs.size();
          y = xk;
          if (k >= 2) y -= 3 * xs[k-2];
          if (k >= 3) y += 3 * xs[k-3];
          if (k >= 4) y -= xs[k-4];
          exp_dout  <= scale(y);
          exp_valid <= 1'b1;
          exp_count <= exp_count + 1;
          if (exp_count >= 2) exp_settled <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      vectors++;
      if (dout !== exp_dout || dout_valid !== exp_valid || settled !== exp_settled) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got dout=%h valid=%b settled=%b want dout=%h valid=%b settled=%b",
                 $time, dout, dout_valid, settled, exp_dout, exp_valid, exp_settled);
      end
    end
  end

  // Stimulus generation
  int mode    = 1;   // 0 zeros, 1 ones, 2 1010, 3 1000, 4 random density
  int en_mode = 0;   // 0 always on, 1 toggle, 2 random 3/4
  int pidx    = 0;
  int dens    = 128;

  function automatic logic pat_bit();
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (pidx % 2) == 0;
      3:       return (pidx % 4) == 0;
      default: return $urandom_range(0, 255) < dens;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) pidx = 0;
    else if (en) pidx++;
    din = pat_bit();
    case (en_mode)
      0:       en = 1'b1;
      1:       en = ~en;
      default: en = $urandom_range(0, 3) != 0;
    endcase
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst  = 1'b0;
    pidx = 0;
    din  = pat_bit();
    en   = 1'b1;
  endtask

  task automatic check_lit(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  task automatic wait_valid(int budget, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!dout_valid && cyc < budget);
    if (!dout_valid) begin
      miscompares++;
      $display("FAIL valid_timeout got none after %0d cycles want a pulse", cyc);
    end
  endtask

  initial begin
    int c;

    // All ones: full scale, settled on third pulse.
    mode = 1; en_mode = 0;
    do_reset(4);
    check_lit("reset_dout", int'(dout), 0);
    check_lit("reset_valid", int'(dout_valid), 0);
    check_lit("reset_settled", int'(settled), 0);
    for (int s = 1; s <= 4; s++) begin
      wait_valid(600, c);
      check_lit("ones_gap", c, 512);
      check_lit("ones_settled", int'(settled), (s >= 3) ? 1 : 0);
      if (s >= 3) check_lit("ones_dout", int'(dout), 'hFFFF);
    end

    // All zeros.
    mode = 0;
    do_reset(4);
    for (int s = 1; s <= 4; s++) begin
      wait_valid(600, c);
      check_lit("zeros_dout", int'(dout), 0);
      check_lit("zeros_settled", int'(settled), (s >= 3) ? 1 : 0);
    end

    // Half and quarter density.
    mode = 2;
    do_reset(4);
    for (int s = 1; s <= 4; s++) begin
      wait_valid(600, c);
      if (s >= 3) check_lit("half_dout", int'(dout), 'h8000);
    end
    mode = 3;
    do_reset(4);
    for (int s = 1; s <= 4; s++) begin
      wait_valid(600, c);
      if (s >= 3) check_lit("quarter_dout", int'(dout), 'h4000);
    end

    // en toggling: 512 accepted bits take 1023 clocks first, then 1024.
    mode = 1; en_mode = 1;
    do_reset(4);
    for (int s = 1; s <= 4; s++) begin
      wait_valid(1100, c);
      check_lit("toggle_gap", c, (s == 1) ? 1023 : 1024);
      if (s >= 3) check_lit("toggle_dout", int'(dout), 'hFFFF);
    end

    // Reset mid-frame discards the partial frame.
    mode = 1; en_mode = 0;
    do_reset(4);
    for (int s = 1; s <= 3; s++) wait_valid(600, c);
    repeat (300) tick();
    check_lit("pre_reset_dout", int'(dout), 'hFFFF);
    do_reset(1);
    check_lit("midrst_dout", int'(dout), 0);
    check_lit("midrst_settled", int'(settled), 0);
    wait_valid(600, c);
    check_lit("midrst_gap", c, 512);

    // Random densities, with always-on and random enables.
    for (int r = 0; r < 4; r++) begin
      mode    = 4;
      dens    = $urandom_range(0, 256);
      en_mode = (r % 2 == 0) ? 0 : 2;
      do_reset(2);
      for (int s = 1; s <= 5; s++) wait_valid(2000, c);
    end

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
